// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: fetches the word at pc_in over a req/ack memory port and
// hands {pc, instr} to decode through a single-entry valid/ready IF/ID buffer.
module if_fetch_stage #(
    parameter int unsigned          ADDR_W    = 64,
    parameter int unsigned          INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'hD503201F,
    parameter int unsigned          TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_stall,
    input  logic               flush,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic               id_fault,
    output logic               bus_error
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          WD_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               fault_q, fault_d;
    logic               berr_q, berr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stall_c;
    logic               slot_free_c;
    logic               wd_hit_c;

    // Next-state, buffer update and PC backpressure
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        fault_d     = fault_q;
        berr_d      = 1'b0;
        cnt_d       = '0;
        stall_c     = 1'b1;
        slot_free_c = !valid_q || id_ready;
        wd_hit_c    = WD_EN && (cnt_q == CNT_W'(TIMEOUT - 1));

        if (valid_q && id_ready) begin
            valid_d = 1'b0;
            fault_d = 1'b0;
            instr_d = NOP_INSTR;
        end

        case (state_q)
            S_IDLE: begin
                if (!flush && slot_free_c) begin
                    if (pc_in[1:0] != 2'b00) begin
                        valid_d = 1'b1;
                        fault_d = 1'b1;
                        pc_d    = pc_in;
                        instr_d = NOP_INSTR;
                        stall_c = 1'b0;
                    end else begin
                        addr_d  = pc_in;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                    if (!flush) begin
                        valid_d = 1'b1;
                        fault_d = 1'b0;
                        pc_d    = addr_q;
                        instr_d = imem_rdata;
                        stall_c = 1'b0;
                    end
                end else if (wd_hit_c) begin
                    state_d = S_IDLE;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = WD_EN ? cnt_q + CNT_W'(1) : '0;
                    if (flush) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Wrong-path fetch still outstanding: wait it out, then drop the data
                if (imem_ack) begin
                    state_d = S_IDLE;
                end else if (wd_hit_c) begin
                    state_d = S_IDLE;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = WD_EN ? cnt_q + CNT_W'(1) : '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush kills the buffered entry even if it was consumed or refilled this cycle
        if (flush) begin
            valid_d = 1'b0;
            fault_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            fault_q <= 1'b0;
            berr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            berr_q  <= berr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req  = (state_q != S_IDLE);
    assign imem_addr = addr_q;
    assign id_valid  = valid_q;
    assign id_pc     = pc_q;
    assign id_instr  = instr_q;
    assign id_fault  = fault_q;
    assign bus_error = berr_q;
    assign pc_stall  = stall_c || !reset;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: PC-register and instruction-memory models drive the
// stage, a scoreboard queue holds the expected IF/ID entries and a monitor retires them.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_in;
    logic        pc_stall;
    logic        flush;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        id_fault;
    logic        bus_error;

    int   n_vec = 0;
    int   n_err = 0;
    int   stall_lows = 0;
    bit   pc_auto = 1'b0;
    bit   ack_en = 1'b1;
    int   wait_cfg = 0;
    int   req_wait = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    if_fetch_stage #(
        .ADDR_W   (64),
        .INSTR_W  (32),
        .NOP_INSTR(32'hD503201F),
        .TIMEOUT  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .pc_stall  (pc_stall),
        .flush     (flush),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc     (id_pc),
        .id_instr  (id_instr),
        .id_fault  (id_fault),
        .bus_error (bus_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h8B020020;
            64'h4:   return 32'hD2800041;
            64'h8:   return 32'h91000421;
            64'hC:   return 32'hF9400022;
            64'h40:  return 32'h14000010;
            64'h100: return 32'hB9400001;
            default: return 32'h00000000;
        endcase
    endfunction

    // Instruction memory: ack after wait_cfg wait cycles, never when ack_en=0
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req !== 1'b1) begin
                req_wait = 0;
                imem_ack = 1'b0;
            end else if (ack_en && req_wait >= wait_cfg) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack = 1'b0;
                req_wait++;
            end
        end
    end

    // Monitor: retire one expected entry per decode handshake
    always @(negedge clk) begin
        if (reset === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_entry: got pc=%h instr=%h fault=%b, required none",
                         id_pc, id_instr, id_fault);
            end else begin
                mon_e = exp_q.pop_front();
                if (id_pc !== mon_e.pc || id_instr !== mon_e.instr || id_fault !== mon_e.fault) begin
                    n_err++;
                    $display("FAIL entry: got pc=%h instr=%h fault=%b, required pc=%h instr=%h fault=%b",
                             id_pc, id_instr, id_fault, mon_e.pc, mon_e.instr, mon_e.fault);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc, input logic [31:0] instr, input logic fault);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.fault = fault;
        exp_q.push_back(e);
    endtask

    // From a sample point (negedge) to the drive point of the next cycle; models the PC register
    task automatic adv_drive();
        bit adv;
        adv = (pc_stall === 1'b0);
        if (adv) stall_lows++;
        @(posedge clk);
        #2;
        if (adv && pc_auto) pc_in = pc_in + 64'd4;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        pc_in    = 64'h6;
        flush    = 1'b0;
        id_ready = 1'b1;

        // Reset state, with a misaligned PC present to show pc_stall is forced high
        settle();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_instr", id_instr, NOP);
        chk("rst_id_fault", id_fault, 0);
        chk("rst_bus_error", bus_error, 0);
        chk("rst_pc_stall", pc_stall, 1);

        // First fetch from 0x0, then stream 0x4
        adv_drive(); reset = 1'b1; pc_in = 64'h0; pc_auto = 1'b1;
        push_exp(64'h0, 32'h8B020020, 1'b0);
        settle();
        chk("c0_pc_stall", pc_stall, 1);
        chk("c0_imem_req", imem_req, 0);
        adv_drive(); settle();
        chk("c1_imem_req", imem_req, 1);
        chk("c1_imem_addr", imem_addr, 64'h0);
        chk("c1_pc_stall", pc_stall, 0);
        adv_drive(); push_exp(64'h4, 32'hD2800041, 1'b0); settle();
        chk("c2_id_valid", id_valid, 1);
        chk("c2_id_pc", id_pc, 64'h0);
        chk("c2_pc_stall", pc_stall, 1);
        adv_drive(); id_ready = 1'b0; settle();
        chk("c3_imem_addr", imem_addr, 64'h4);
        chk("c3_pc_stall", pc_stall, 0);

        // Decode stalls with entry 0x4 buffered: no new request, entry stable
        for (int i = 0; i < 3; i++) begin
            adv_drive(); settle();
            chk("hold_imem_req", imem_req, 0);
            chk("hold_id_valid", id_valid, 1);
            chk("hold_id_pc", id_pc, 64'h4);
            chk("hold_id_instr", id_instr, 32'hD2800041);
            chk("hold_pc_stall", pc_stall, 1);
        end
        adv_drive(); id_ready = 1'b1; push_exp(64'h8, 32'h91000421, 1'b0); settle();
        chk("c7_imem_req", imem_req, 0);
        chk("c7_pc_stall", pc_stall, 1);
        adv_drive(); wait_cfg = 3; settle();
        chk("c8_imem_addr", imem_addr, 64'h8);
        chk("c8_pc_stall", pc_stall, 0);

        // Flush during a slow fetch of 0xC: drain it, then fetch the new target 0x40
        adv_drive(); settle();
        chk("c9_imem_req", imem_req, 0);
        adv_drive(); flush = 1'b1; pc_in = 64'h40; settle();
        chk("c10_imem_addr", imem_addr, 64'hC);
        chk("c10_pc_stall", pc_stall, 1);
        adv_drive(); flush = 1'b0; push_exp(64'h40, 32'h14000010, 1'b0); settle();
        chk("drain_imem_req", imem_req, 1);
        chk("drain_imem_addr", imem_addr, 64'hC);
        chk("drain_id_valid", id_valid, 0);
        adv_drive(); settle();
        adv_drive(); wait_cfg = 0; settle();
        chk("drain_ack_seen", imem_ack, 1);
        chk("drain_ack_pc_stall", pc_stall, 1);
        adv_drive(); settle();
        chk("c14_id_valid", id_valid, 0);
        chk("c14_imem_req", imem_req, 0);
        chk("c14_bus_error", bus_error, 0);
        adv_drive(); settle();
        chk("c15_imem_addr", imem_addr, 64'h40);
        chk("c15_pc_stall", pc_stall, 0);

        // Misaligned PC 0x6 produces a fault entry without a memory request
        adv_drive(); pc_auto = 1'b0; pc_in = 64'h6; push_exp(64'h6, NOP, 1'b1); settle();
        chk("c16_pc_stall", pc_stall, 0);
        chk("c16_imem_req", imem_req, 0);
        adv_drive(); id_ready = 1'b0; pc_in = 64'h100; settle();
        chk("fault_id_valid", id_valid, 1);
        chk("fault_id_fault", id_fault, 1);
        chk("fault_id_pc", id_pc, 64'h6);
        chk("fault_id_instr", id_instr, NOP);
        chk("fault_imem_req", imem_req, 0);
        chk("fault_pc_stall", pc_stall, 1);

        // Watchdog: memory never answers the fetch of 0x100
        adv_drive(); id_ready = 1'b1; ack_en = 1'b0; settle();
        for (int i = 0; i < 4; i++) begin
            adv_drive(); settle();
            chk("wd_wait_imem_req", imem_req, 1);
            chk("wd_wait_bus_error", bus_error, 0);
            chk("wd_wait_pc_stall", pc_stall, 1);
        end
        adv_drive(); settle();
        chk("wd_bus_error", bus_error, 1);
        chk("wd_imem_req", imem_req, 0);
        chk("wd_pc_stall", pc_stall, 1);
        chk("wd_id_valid", id_valid, 0);
        adv_drive(); settle();
        chk("refetch_imem_req", imem_req, 1);
        chk("refetch_imem_addr", imem_addr, 64'h100);
        chk("refetch_bus_error", bus_error, 0);

        // Reset mid-request drops imem_req before any clock edge
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_imem_req", imem_req, 0);
        chk("async_rst_imem_addr", imem_addr, 0);
        chk("async_rst_pc_stall", pc_stall, 1);
        @(posedge clk);
        #2;
        reset  = 1'b1;
        ack_en = 1'b1;
        push_exp(64'h100, 32'hB9400001, 1'b0);
        settle();
        chk("r0_imem_req", imem_req, 0);
        adv_drive(); settle();
        chk("r1_imem_addr", imem_addr, 64'h100);
        chk("r1_pc_stall", pc_stall, 0);
        adv_drive(); flush = 1'b1; settle();
        chk("r2_id_valid", id_valid, 1);
        adv_drive(); settle();
        chk("r3_id_valid", id_valid, 0);
        chk("r3_imem_req", imem_req, 0);

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            adv_drive(); settle();
        end
        chk("scoreboard_drained", 64'(exp_q.size()), 0);
        chk("pc_stall_low_cycles", 64'(stall_lows), 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no end of test, required completion before 100000");
        $fatal(1);
    end

endmodule
